// File: rtl/leds_pio_arbiter_pkg.sv
// Purpose: shared types and constants for the LED PIO arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package leds_pio_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      ACK   = 3'd3,
      HOLD  = 3'd4
   } arb_state_t;

   // PIO register 0 is the output data register.
   localparam logic [1:0] PIO_REG_DATA  = 2'd0;
   localparam int         LED_W_DEFAULT = 14;

   // Width of an index into n items, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/leds_pio_arbiter_if.sv
// Purpose: slave-side pin bundle of the Avalon-MM LED PIO.
// Latency: n/a (wires only).
// Backpressure: none; the PIO accepts every single-cycle access.
interface leds_pio_if;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic [31:0] pio_readdata;

   modport master (
      output pio_address,
      output pio_chipselect,
      output pio_write_n,
      output pio_writedata,
      input  pio_readdata
   );

   modport slave (
      input  pio_address,
      input  pio_chipselect,
      input  pio_write_n,
      input  pio_writedata,
      output pio_readdata
   );
endinterface

// File: rtl/leds_pio_arbiter_rr_picker.sv
// Purpose: round-robin winner selection over a request vector.
// Latency: combinational.
// Backpressure: none; caller decides when to consume the pick.
module rr_picker
   import leds_pio_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    rr_last,
   output logic             found,
   output logic [IW-1:0]    winner
);

   // Scan from the farthest rotated offset back towards rr_last+1 so the
   // nearest asserted requester after rr_last is the last one written.
   always_comb begin
      winner = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(rr_last) + k) % N_REQ]) begin
            winner = IW'((int'(rr_last) + k) % N_REQ);
         end
      end
   end

   assign found = |req;

endmodule

// File: rtl/leds_pio_arbiter.sv
// Purpose: round-robin sharing of the LED PIO data register; optional readback via LEDS_PIO_ARB_READBACK_EN.
// Latency: req seen in IDLE at t -> write strobe t+1 -> ack t+2 (t+3 with readback), then HOLD_CYCLES of hold.
// Backpressure: requests are levels; losers and requests arriving while busy simply wait for a later grant.
module leds_pio_arbiter
   import leds_pio_arb_pkg::*;
#(
   parameter  int N_REQ       = 4,
   parameter  int LED_W       = LED_W_DEFAULT,
   parameter  int HOLD_CYCLES = 0,
   localparam int IW          = idx_width(N_REQ)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LED_W-1:0] req_data,
   output logic [N_REQ-1:0]       ack,
   leds_pio_if.master             pio,
   output logic [IW-1:0]          owner,
   output logic                   busy,
   output logic                   err_mismatch
);

   // Counter only ever holds HOLD_CYCLES-1 down to 0.
   localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   arb_state_t        state, state_d;
   logic [IW-1:0]     win_q;
   logic [IW-1:0]     rr_last;
   logic [IW-1:0]     pick_idx;
   logic              pick_found;
   logic [LED_W-1:0]  pick_data;
   logic [HW-1:0]     hold_cnt;

   rr_picker #(.N_REQ(N_REQ)) u_rr_picker (
      .req     (req),
      .rr_last (rr_last),
      .found   (pick_found),
      .winner  (pick_idx)
   );

   assign pick_data = req_data[int'(pick_idx)*LED_W +: LED_W];
   assign busy      = (state != IDLE);

   // Next-state decode.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (pick_found) state_d = WRITE;
`ifdef LEDS_PIO_ARB_READBACK_EN
         WRITE: state_d = READ;
`else
         WRITE: state_d = ACK;
`endif
         READ:  state_d = ACK;
         ACK:   state_d = (HOLD_CYCLES > 0) ? HOLD : IDLE;
         HOLD:  if (hold_cnt == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus per-transaction bookkeeping (winner, round-robin pointer, hold timer).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         win_q    <= '0;
         rr_last  <= IW'(N_REQ - 1);
         owner    <= '0;
         hold_cnt <= '0;
      end else begin
         state <= state_d;
         case (state)
            IDLE: if (pick_found) win_q <= pick_idx;
            ACK: begin
               owner    <= win_q;
               rr_last  <= win_q;
               hold_cnt <= HOLD_LOAD;
            end
            HOLD: if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // Moore outputs registered from the next state; writedata doubles as the latched pattern.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack                <= '0;
         pio.pio_chipselect <= 1'b0;
         pio.pio_write_n    <= 1'b1;
         pio.pio_address    <= PIO_REG_DATA;
         pio.pio_writedata  <= '0;
      end else begin
         ack                <= '0;
         pio.pio_chipselect <= 1'b0;
         pio.pio_write_n    <= 1'b1;
         pio.pio_address    <= PIO_REG_DATA;
         case (state_d)
            WRITE: begin
               pio.pio_chipselect <= 1'b1;
               pio.pio_write_n    <= 1'b0;
               // WRITE is only ever entered from IDLE, so the live pick is the winner.
               pio.pio_writedata  <= 32'(pick_data);
            end
            READ:  pio.pio_chipselect <= 1'b1;
            ACK:   ack <= N_REQ'(1) << win_q;
            default: ;
         endcase
      end
   end

`ifdef LEDS_PIO_ARB_READBACK_EN
   logic unused_rd_hi;
   assign unused_rd_hi = ^(pio.pio_readdata >> LED_W);

   // Sticky flag: the PIO did not hold the pattern we just wrote.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_mismatch <= 1'b0;
      end else if (state == READ &&
                   pio.pio_readdata[LED_W-1:0] != pio.pio_writedata[LED_W-1:0]) begin
         err_mismatch <= 1'b1;
      end
   end
`else
   logic unused_rd;
   assign unused_rd    = ^pio.pio_readdata;
   assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_leds_pio_arbiter.sv
// Purpose: self-checking bench for leds_pio_arbiter (round-robin order, latency, hold, reset, readback).
// Latency: checks write at t+1 and ack at t+2 (+1 with readback) after a request is seen.
// Backpressure: requests are held as levels and dropped in the ack cycle.
module tb_leds_pio_arbiter;
   localparam int N = 4;
   localparam int W = 14;
`ifdef LEDS_PIO_ARB_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT with no hold time
   logic [N-1:0]   req0 = '0;
   logic [N*W-1:0] dat0 = '0;
   logic [N-1:0]   ack0;
   logic [1:0]     own0;
   logic           busy0, err0;
   logic [31:0]    pio_reg0 = '0;
   logic           rd_zero = 1'b0;
   leds_pio_if     pio0();

   always @(posedge clk)
      if (pio0.pio_chipselect && !pio0.pio_write_n) pio_reg0 <= pio0.pio_writedata;
   assign pio0.pio_readdata = rd_zero ? 32'h0 : pio_reg0;

   leds_pio_arbiter #(.N_REQ(N), .LED_W(W), .HOLD_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .req(req0), .req_data(dat0), .ack(ack0),
      .pio(pio0), .owner(own0), .busy(busy0), .err_mismatch(err0));

   // DUT with a 5-cycle hold
   logic [N-1:0]   req5 = '0;
   logic [N*W-1:0] dat5 = '0;
   logic [N-1:0]   ack5;
   logic [1:0]     own5;
   logic           busy5, err5;
   logic [31:0]    pio_reg5 = '0;
   leds_pio_if     pio5();

   always @(posedge clk)
      if (pio5.pio_chipselect && !pio5.pio_write_n) pio_reg5 <= pio5.pio_writedata;
   assign pio5.pio_readdata = pio_reg5;

   leds_pio_arbiter #(.N_REQ(N), .LED_W(W), .HOLD_CYCLES(5)) dut5 (
      .clk(clk), .reset_n(reset_n), .req(req5), .req_data(dat5), .ack(ack5),
      .pio(pio5), .owner(own5), .busy(busy5), .err_mismatch(err5));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard for dut0
   typedef struct { int idx; logic [W-1:0] dat; } exp_t;
   exp_t exp_q[$];
   int   ack_q[$];
   int   wr_cyc_q[$];
   exp_t mon_e;
   int   mon_i;

   always @(negedge clk) begin
      if (reset_n) begin
         if (pio0.pio_chipselect && !pio0.pio_write_n) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_write: unexpected write of %0h, none expected", pio0.pio_writedata);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_wdata", pio0.pio_writedata, 32'(mon_e.dat));
               check("sb_addr", 32'(pio0.pio_address), 32'd0);
               ack_q.push_back(mon_e.idx);
            end
         end
         if (ack0 != '0) begin
            if (ack_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_ack: unexpected ack %0h, none expected", ack0);
            end else begin
               mon_i = ack_q.pop_front();
               check("sb_ack", 32'(ack0), 32'(1) << mon_i);
            end
         end
      end
   end

   task automatic push_exp(input int idx, input logic [W-1:0] d);
      exp_t e;
      e.idx = idx;
      e.dat = d;
      exp_q.push_back(e);
   endtask

   // Negedges until dut0 strobes a write; -1 on timeout.
   task automatic wait_wr0(output int k);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (pio0.pio_chipselect && !pio0.pio_write_n) begin
            k = i;
            return;
         end
      end
   endtask

   // Negedges until dut0 pulses any ack; -1 on timeout.
   task automatic wait_ack0(output int k, output logic [N-1:0] a);
      k = -1;
      a = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (ack0 != '0) begin
            k = i;
            a = ack0;
            return;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req0 = '0;
      req5 = '0;
      exp_q.delete();
      ack_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [W-1:0] d [N];
      int           win;
   } vec_t;
   vec_t vec[8];

   task automatic set_vec(input int e, input logic [N-1:0] r, input int w);
      vec[e].req = r;
      vec[e].win = w;
      for (int i = 0; i < N; i++) vec[e].d[i] = W'(32'h1357 * (e + 1) + 32'h00A5 * i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int n_ack;
      int nw;
      int w [2];
      logic [N-1:0] a;
      logic [W-1:0] ed;

      // Round-robin sequence starting from reset (rr_last = 3).
      set_vec(0, 4'b0001, 0);
      vec[0].d[0] = 14'h2AAA;
      set_vec(1, 4'b0110, 1);
      set_vec(2, 4'b0110, 2);
      set_vec(3, 4'b1001, 3);
      set_vec(4, 4'b1001, 0);
      set_vec(5, 4'b0001, 0);
      set_vec(6, 4'b1100, 2);
      set_vec(7, 4'b0011, 0);

      // Reset values
      #12;
      check("rst_ack", 32'(ack0), 32'd0);
      check("rst_cs", 32'(pio0.pio_chipselect), 32'd0);
      check("rst_wn", 32'(pio0.pio_write_n), 32'd1);
      check("rst_addr", 32'(pio0.pio_address), 32'd0);
      check("rst_wdata", pio0.pio_writedata, 32'd0);
      check("rst_owner", 32'(own0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Table-driven single transactions
      for (int e = 0; e < 8; e++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) dat0[i*W +: W] = vec[e].d[i];
         req0 = vec[e].req;
         ed = vec[e].d[vec[e].win];
         push_exp(vec[e].win, ed);
         wait_wr0(k);
         check("lat_write", 32'(k), 32'd1);
         wait_ack0(k, a);
         req0 = '0;
         check("lat_ack", 32'(k), 32'(1 + RB));
         check("ack_vec", 32'(a), 32'(1) << vec[e].win);
         @(negedge clk);
         check("owner", 32'(own0), 32'(vec[e].win));
         check("busy_idle", 32'(busy0), 32'd0);
      end

      // All four requesting continuously from reset: 0,1,2,3,0 at fixed spacing
      do_reset();
      wr_cyc_q.delete();
      for (int i = 0; i < N; i++) dat0[i*W +: W] = W'(32'h0100 + i);
      push_exp(0, 14'h0100);
      push_exp(1, 14'h0101);
      push_exp(2, 14'h0102);
      push_exp(3, 14'h0103);
      push_exp(0, 14'h0100);
      @(negedge clk);
      req0 = 4'b1111;
      n_ack = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ack0 != '0) begin
            n_ack++;
            if (n_ack == 5) begin
               req0 = '0;
               break;
            end
         end
      end
      check("rr_acks", 32'(n_ack), 32'd5);
      repeat (6) @(negedge clk);
      check("rr_writes", 32'(wr_cyc_q.size()), 32'd5);
      for (int i = 1; i < wr_cyc_q.size(); i++)
         check("rr_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'(3 + RB));
      check("rr_drained", 32'(exp_q.size()), 32'd0);

      // Data changed and request dropped during WRITE: original data, ack still pulses
      @(negedge clk);
      dat0[2*W +: W] = 14'h1234;
      req0 = 4'b0100;
      push_exp(2, 14'h1234);
      wait_wr0(k);
      dat0[2*W +: W] = 14'h3FFF;
      req0 = '0;
      check("drop_lat_write", 32'(k), 32'd1);
      wait_ack0(k, a);
      check("drop_ack", 32'(a), 32'b0100);
      @(negedge clk);
      check("drop_busy", 32'(busy0), 32'd0);

      // Reset during ACK: no ack survives, requester 0 wins afterwards
      @(negedge clk);
      dat0[3*W +: W] = 14'h0F0F;
      req0 = 4'b1000;
      push_exp(3, 14'h0F0F);
      wait_wr0(k);
      check("rstack_lat_write", 32'(k), 32'd1);
      repeat (RB) @(negedge clk);
      @(posedge clk);
      #1;
      check("rstack_in_ack", 32'(ack0), 32'b1000);
      reset_n = 1'b0;
      #1;
      check("rstack_ack_clr", 32'(ack0), 32'd0);
      check("rstack_busy", 32'(busy0), 32'd0);
      check("rstack_cs", 32'(pio0.pio_chipselect), 32'd0);
      exp_q.delete();
      ack_q.delete();
      @(negedge clk);
      dat0[0 +: W] = 14'h0555;
      req0 = 4'b1001;
      push_exp(0, 14'h0555);
      reset_n = 1'b1;
      wait_wr0(k);
      check("rstack_next_write", 32'(k), 32'd1);
      wait_ack0(k, a);
      req0 = '0;
      check("rstack_next_ack", 32'(a), 32'b0001);

      // Readback with the PIO returning zero
      @(negedge clk);
      rd_zero = 1'b1;
      dat0[0 +: W] = 14'h0001;
      req0 = 4'b0001;
      push_exp(0, 14'h0001);
      wait_wr0(k);
      wait_ack0(k, a);
      req0 = '0;
      check("rb_lat_ack", 32'(k), 32'(1 + RB));
      check("rb_ack", 32'(a), 32'b0001);
      @(negedge clk);
      check("rb_err", 32'(err0), 32'(RB));
      repeat (3) @(negedge clk);
      check("rb_err_sticky", 32'(err0), 32'(RB));
      rd_zero = 1'b0;
      dat0[1*W +: W] = 14'h002B;
      req0 = 4'b0010;
      push_exp(1, 14'h002B);
      wait_wr0(k);
      wait_ack0(k, a);
      req0 = '0;
      check("rb_ack2", 32'(a), 32'b0010);
      @(negedge clk);
      check("rb_err_held", 32'(err0), 32'(RB));

      // Hold time: two held requesters on the HOLD_CYCLES=5 instance
      @(negedge clk);
      dat5[0 +: W] = 14'h1111;
      dat5[1*W +: W] = 14'h2222;
      req5 = 4'b0011;
      nw = 0;
      n_ack = 0;
      w[0] = 0;
      w[1] = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (pio5.pio_chipselect && !pio5.pio_write_n) begin
            if (nw < 2) begin
               w[nw] = cyc;
               check("hold_wdata", pio5.pio_writedata, (nw == 0) ? 32'h1111 : 32'h2222);
            end
            nw++;
         end
         if (ack5 != '0) begin
            check("hold_ack", 32'(ack5), (n_ack == 0) ? 32'b0001 : 32'b0010);
            n_ack++;
            if (n_ack == 2) begin
               req5 = '0;
               break;
            end
         end
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (pio5.pio_chipselect && !pio5.pio_write_n) nw++;
      end
      check("hold_writes", 32'(nw), 32'd2);
      check("hold_spacing", 32'(w[1] - w[0]), 32'(8 + RB));
      check("hold_owner", 32'(own5), 32'd1);
      check("sb_left", 32'(exp_q.size() + ack_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
